// File: rtl/hud_pkg.sv
// Shared constants and helpers for the HUD score path.
// XVGA geometry plus BCD digit parameters.
package hud_pkg;

    localparam int H_ACTIVE  = 1024;
    localparam int V_ACTIVE  = 768;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DRUMS = 16;
    localparam int BCD_MAX   = 9;

    // Single-digit BCD increment; 9 wraps to 0 with no carry.
    function automatic logic [DIGIT_W-1:0] bcd_inc(
        input logic [DIGIT_W-1:0] d
    );
        return (d >= DIGIT_W'(BCD_MAX)) ? '0 : d + 1'b1;
    endfunction

endpackage

// File: rtl/hud_score_writer_digit.sv
// One wrapping BCD hit counter; clear beats inc.
// Module name bcd_digit, instantiated once per drum.
module bcd_digit
    import hud_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [DIGIT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= bcd_inc(count);
        end
    end

endmodule

// File: rtl/hud_score_writer.sv
// Per-drum BCD hit counters with a blanking-only drain of
// digit updates into hud_digits, one write per cycle.
module hud_score_writer
    import hud_pkg::*;
#(
    parameter int NUM_DRUMS = 4,
    parameter int V_ACTIVE  = hud_pkg::V_ACTIVE
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_DRUMS-1:0]         hit,
    input  logic                         clear,
    input  logic [9:0]                   vcount,
    output logic                         write,
    output logic [DIGIT_W-1:0]           num,
    output logic [3:0]                   blob,
    output logic [DIGIT_W*NUM_DRUMS-1:0] counts
);

    localparam logic [9:0] VA = 10'(V_ACTIVE);

    logic [NUM_DRUMS-1:0] pending;
    logic [NUM_DRUMS-1:0] pending_nxt;
    logic [NUM_DRUMS-1:0] sel_oh;
    logic [3:0]           sel;
    logic [DIGIT_W-1:0]   sel_num;
    logic                 blanking;
    logic                 drain;

    for (genvar g = 0; g < NUM_DRUMS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (hit[g]),
            .count (counts[DIGIT_W*g +: DIGIT_W])
        );
    end

    // Lowest pending index wins; descending scan keeps the last match.
    always_comb begin
        sel     = '0;
        sel_oh  = '0;
        sel_num = '0;
        for (int i = NUM_DRUMS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel       = 4'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_num   = counts[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

    always_comb begin
        blanking    = (vcount >= VA);
        drain       = blanking && (|pending);
        pending_nxt = clear ? '1 : (pending | hit);
        // A hit on the drum being sent keeps it pending for the new value.
        if (drain && !clear) begin
            pending_nxt = pending_nxt & ~(sel_oh & ~hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '1;
            write   <= 1'b0;
            num     <= '0;
            blob    <= '0;
        end else begin
            pending <= pending_nxt;
            write   <= drain;
            if (drain) begin
                num  <= sel_num;
                blob <= sel;
            end
        end
    end

endmodule

// File: tb/tb_hud_score_writer.sv
// Directed bench for hud_score_writer: reset init, hit counting,
// wrap, priority drain, hit-on-select, clear-vs-hit, reset abort.
module tb_hud_score_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hit;
    logic        clear;
    logic [9:0]  vcount;
    logic        write;
    logic [3:0]  num;
    logic [3:0]  blob;
    logic [15:0] counts;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int wl_blob[$];
    int wl_num[$];
    int wl_cyc[$];

    hud_score_writer #(.NUM_DRUMS(4), .V_ACTIVE(768)) dut (
        .clk    (clk),
        .reset  (reset),
        .hit    (hit),
        .clear  (clear),
        .vcount (vcount),
        .write  (write),
        .num    (num),
        .blob   (blob),
        .counts (counts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write === 1'b1) begin
            wl_blob.push_back(int'(blob));
            wl_num.push_back(int'(num));
            wl_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic log_clear();
        wl_blob.delete();
        wl_num.delete();
        wl_cyc.delete();
    endtask

    // Expect n writes, blobs 0..n-1 in order, all carrying exp_num.
    task automatic check_seq(input string tag, input int n, input int exp_num);
        check({tag, "_size"}, wl_blob.size(), n);
        for (int i = 0; i < n && i < wl_blob.size(); i++) begin
            check($sformatf("%s_blob%0d", tag, i), wl_blob[i], i);
            check($sformatf("%s_num%0d", tag, i), wl_num[i], exp_num);
            if (i > 0)
                check($sformatf("%s_gap%0d", tag, i), wl_cyc[i] - wl_cyc[i-1], 1);
        end
    endtask

    initial begin
        reset  = 1'b1;
        hit    = '0;
        clear  = 1'b0;
        vcount = 10'd0;
        tick(3);
        check("rst_write", int'(write), 0);
        check("rst_num", int'(num), 0);
        check("rst_blob", int'(blob), 0);
        check("rst_counts", int'(counts), 0);

        // Reset release: nothing until blanking, then four zero writes.
        reset = 1'b0;
        tick(5);
        check("init_idle", wl_blob.size(), 0);
        vcount = 10'd768;
        tick(8);
        check_seq("init", 4, 0);
        vcount = 10'd0;
        tick(1);
        log_clear();

        // Three hits on drum 2 in active video, one write later.
        for (int k = 0; k < 3; k++) begin
            hit = 4'b0100; tick(1);
            hit = 4'b0000; tick(1);
        end
        check("h2_counts", int'(counts[11:8]), 3);
        check("h2_nowrite", wl_blob.size(), 0);
        vcount = 10'd768;
        tick(5);
        check("h2_size", wl_blob.size(), 1);
        if (wl_blob.size() > 0) begin
            check("h2_blob", wl_blob[0], 2);
            check("h2_num", wl_num[0], 3);
        end
        vcount = 10'd0;
        tick(1);
        log_clear();

        // Ten hits on drum 1 wrap back to zero.
        for (int k = 0; k < 10; k++) begin
            hit = 4'b0010; tick(1);
        end
        hit = 4'b0000;
        tick(1);
        check("wrap_counts", int'(counts[7:4]), 0);
        vcount = 10'd768;
        tick(5);
        check("wrap_size", wl_blob.size(), 1);
        if (wl_blob.size() > 0) begin
            check("wrap_blob", wl_blob[0], 1);
            check("wrap_num", wl_num[0], 0);
        end

        // Two drums hit at once during blanking: exact latency.
        tick(2);
        hit = 4'b1001; tick(1);
        hit = 4'b0000;
        check("multi_t1_write", int'(write), 0);
        tick(1);
        check("multi_t2_write", int'(write), 1);
        check("multi_t2_blob", int'(blob), 0);
        check("multi_t2_num", int'(num), 1);
        tick(1);
        check("multi_t3_write", int'(write), 1);
        check("multi_t3_blob", int'(blob), 3);
        check("multi_t3_num", int'(num), 1);
        tick(1);
        check("multi_t4_write", int'(write), 0);
        check("multi_hold_blob", int'(blob), 3);
        check("multi_counts", int'(counts), 16'h1301);

        // Hit on drum 0 in the very cycle it is selected.
        vcount = 10'd0;
        hit = 4'b0001; tick(1);
        hit = 4'b0000; tick(1);
        vcount = 10'd768;
        hit = 4'b0001; tick(1);
        hit = 4'b0000;
        check("sel_w1_write", int'(write), 1);
        check("sel_w1_blob", int'(blob), 0);
        check("sel_w1_num", int'(num), 2);
        tick(1);
        check("sel_w2_write", int'(write), 1);
        check("sel_w2_blob", int'(blob), 0);
        check("sel_w2_num", int'(num), 3);
        tick(1);
        check("sel_w3_write", int'(write), 0);

        // Clear beats a simultaneous hit on drum 3.
        vcount = 10'd0;
        clear = 1'b1; tick(1);
        clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            hit = 4'b1111; tick(1);
        end
        hit = 4'b0000;
        tick(1);
        check("clr_pre_counts", int'(counts), 16'h5555);
        clear = 1'b1;
        hit = 4'b1000; tick(1);
        clear = 1'b0;
        hit = 4'b0000;
        check("clr_counts", int'(counts), 0);
        tick(1);
        log_clear();
        vcount = 10'd768;
        tick(6);
        check_seq("clr", 4, 0);
        check("clr_counts_after", int'(counts), 0);

        // Reset in the middle of a drain.
        vcount = 10'd0;
        hit = 4'b1111; tick(1);
        hit = 4'b0000;
        vcount = 10'd768;
        tick(1);
        check("abort_pre_write", int'(write), 1);
        reset = 1'b1; tick(1);
        check("abort_write", int'(write), 0);
        check("abort_counts", int'(counts), 0);
        reset = 1'b0;
        vcount = 10'd0;
        tick(3);
        check("abort_idle_write", int'(write), 0);
        log_clear();
        vcount = 10'd768;
        tick(6);
        check_seq("reinit", 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
